// File: rtl/dbg_word_loader.sv
// Purpose: parses framed program loads (header, base address, N data words, checksum) from the UART word receiver and writes them to instruction memory.
// Latency: a data word's mem_req rises 1 cycle after its word_end event; load_done pulses 1 cycle after a matching checksum event.
// Backpressure: mem_req holds address and data until mem_ready; an incoming word while a write is pending is an overrun error.
module dbg_word_loader #(
    parameter logic [15:0] MAGIC          = 16'hB007,
    parameter int          TIMEOUT_CYCLES = 50_000_000,
    parameter int          TW             = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] word_in,
    input  logic        word_end,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [1:0]  err_code,
    output logic [15:0] words_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_OVERRUN = 2'd1;
    localparam logic [1:0] ERR_ALIGN   = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          word_end_q;
    logic          evt;
    logic          hdr_ok;
    logic          tmo_hit;
    logic [31:0]   addr;
    logic [31:0]   csum;
    logic [TW-1:0] tmo_cnt;

    // word_end may stay high for several cycles; only its rising edge is a word
    assign evt     = word_end & ~word_end_q;
    assign hdr_ok  = (word_in[31:16] == MAGIC) && (word_in[15:0] != 16'd0);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Delay word_end by one cycle for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_end_q <= 1'b0;
        end else begin
            word_end_q <= word_end;
        end
    end

    // Load sequencer: header -> address -> (data -> write) x N -> checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= 2'd0;
            words_left <= 16'd0;
            addr       <= 32'd0;
            csum       <= 32'd0;
            tmo_cnt    <= '0;
        end else begin
            load_done <= 1'b0;
            // Idle counter is zero outside the waiting states and after every word
            tmo_cnt   <= '0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (evt && hdr_ok) begin
                        words_left <= word_in[15:0];
                        csum       <= 32'd0;
                        cpu_hold   <= 1'b1;
                        load_err   <= 1'b0;
                        err_code   <= 2'd0;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (evt) begin
                        if (word_in[1:0] != 2'd0) begin
                            state    <= S_ERROR;
                            load_err <= 1'b1;
                            err_code <= ERR_ALIGN;
                        end else begin
                            addr  <= word_in;
                            state <= S_DATA;
                        end
                    end else if (tmo_hit) begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (evt) begin
                        mem_addr  <= addr;
                        mem_wdata <= word_in;
                        mem_req   <= 1'b1;
                        csum      <= csum + word_in;
                        state     <= S_WRITE;
                    end else if (tmo_hit) begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    // An accept in the same cycle as an overrun still counts
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        addr       <= addr + 32'd4;
                        words_left <= words_left - 16'd1;
                        state      <= (words_left == 16'd1) ? S_CSUM : S_DATA;
                    end
                    if (evt) begin
                        mem_req  <= 1'b0;
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        err_code <= ERR_OVERRUN;
                    end
                end
                S_CSUM: begin
                    if (evt) begin
                        if (word_in == csum) begin
                            load_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state    <= S_ERROR;
                            load_err <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end else if (tmo_hit) begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_word_loader.sv
// Purpose: directed-vector bench for dbg_word_loader with hand-computed expectations.
// Latency: inputs change 1 time unit after posedge, outputs sampled on negedge or 1 unit after posedge.
// Backpressure: mem_ready is driven per scenario to exercise stalls and overrun.
module tb_dbg_word_loader;

    logic        clk;
    logic        reset;
    logic [31:0] word_in;
    logic        word_end;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;
    logic [15:0] words_left;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    int          done_cnt = 0;
    int          req_cyc  = 0;
    int          base;

    dbg_word_loader #(
        .MAGIC         (16'hB007),
        .TIMEOUT_CYCLES(100),
        .TW            (27)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .word_in   (word_in),
        .word_end  (word_end),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code),
        .words_left(words_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: record accepted writes, request cycles and done pulses
    always @(negedge clk) begin
        if (reset) begin
            if (mem_req) req_cyc++;
            if (mem_req && mem_ready) begin
                wq_a.push_back(mem_addr);
                wq_d.push_back(mem_wdata);
            end
            if (load_done) done_cnt++;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one word with word_end high for 'hold' cycles, then idle 3 cycles
    task automatic send_word(input logic [31:0] w, input int hold);
        @(posedge clk); #1;
        word_in  = w;
        word_end = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        word_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load2(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] cs, input int hold);
        send_word(32'hB007_0002, hold);
        send_word(a, hold);
        send_word(d0, hold);
        send_word(d1, hold);
        send_word(cs, hold);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        word_in   = 32'd0;
        word_end  = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        check_vec("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_vec("rst_mem_addr", mem_addr, 32'd0);
        check_vec("rst_mem_wdata", mem_wdata, 32'd0);
        check_vec("rst_flags", {28'd0, cpu_hold, load_done, load_err, 1'b0}, 32'd0);
        check_vec("rst_err_code", {30'd0, err_code}, 32'd0);
        check_vec("rst_words_left", {16'd0, words_left}, 32'd0);
        reset = 1'b1;

        // 1. Normal load with step-by-step checks
        send_word(32'hB007_0002, 1);
        check_vec("t1_hold_hdr", {31'd0, cpu_hold}, 32'd1);
        check_vec("t1_wl_2", {16'd0, words_left}, 32'd2);
        send_word(32'h0000_0100, 1);
        send_word(32'h1111_1111, 1);
        check_vec("t1_wl_1", {16'd0, words_left}, 32'd1);
        check_vec("t1_hold_d1", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h2222_2222, 1);
        check_vec("t1_wl_0", {16'd0, words_left}, 32'd0);
        send_word(32'h3333_3333, 1);
        check_vec("t1_nwr", wq_a.size(), 32'd2);
        check_vec("t1_a0", wq_a[0], 32'h0000_0100);
        check_vec("t1_d0", wq_d[0], 32'h1111_1111);
        check_vec("t1_a1", wq_a[1], 32'h0000_0104);
        check_vec("t1_d1", wq_d[1], 32'h2222_2222);
        check_vec("t1_req_cyc", req_cyc, 32'd2);
        check_vec("t1_done", done_cnt, 32'd1);
        check_vec("t1_hold_end", {31'd0, cpu_hold}, 32'd0);
        check_vec("t1_err", {31'd0, load_err}, 32'd0);

        // 2. Checksum mismatch, then recovery by a fresh header
        load2(32'h0000_0100, 32'h1111_1111, 32'h2222_2222, 32'h3333_3334, 1);
        check_vec("t2_err", {31'd0, load_err}, 32'd1);
        check_vec("t2_code", {30'd0, err_code}, 32'd3);
        check_vec("t2_hold", {31'd0, cpu_hold}, 32'd1);
        check_vec("t2_done", done_cnt, 32'd1);
        send_word(32'hB007_0002, 1);
        check_vec("t2_err_clr", {31'd0, load_err}, 32'd0);
        send_word(32'h0000_0100, 1);
        send_word(32'h1111_1111, 1);
        send_word(32'h2222_2222, 1);
        send_word(32'h3333_3333, 1);
        check_vec("t2_done_again", done_cnt, 32'd2);
        check_vec("t2_hold_rel", {31'd0, cpu_hold}, 32'd0);

        // 3. Misaligned address
        base = req_cyc;
        send_word(32'hB007_0001, 1);
        send_word(32'h0000_0102, 1);
        check_vec("t3_err", {31'd0, load_err}, 32'd1);
        check_vec("t3_code", {30'd0, err_code}, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        check_vec("t3_no_req", req_cyc, base);

        // 4. Overrun while a write is stalled
        mem_ready = 1'b0;
        base = wq_a.size();
        send_word(32'hB007_0002, 1);
        send_word(32'h0000_0200, 1);
        send_word(32'hAAAA_0001, 1);
        check_vec("t4_req_held", {31'd0, mem_req}, 32'd1);
        check_vec("t4_addr", mem_addr, 32'h0000_0200);
        check_vec("t4_wdata", mem_wdata, 32'hAAAA_0001);
        @(posedge clk); #1;
        word_in  = 32'hAAAA_0002;
        word_end = 1'b1;
        @(posedge clk); #1;
        check_vec("t4_req_drop", {31'd0, mem_req}, 32'd0);
        check_vec("t4_code", {30'd0, err_code}, 32'd1);
        check_vec("t4_err", {31'd0, load_err}, 32'd1);
        check_vec("t4_wl", {16'd0, words_left}, 32'd2);
        word_end  = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_vec("t4_no_write", wq_a.size(), base);

        // 5. Long word_end pulses, ignored words in IDLE
        do_reset();
        base = wq_a.size();
        send_word(32'h0000_0041, 2);
        check_vec("t5_ign_hold", {31'd0, cpu_hold}, 32'd0);
        check_vec("t5_ign_wl", {16'd0, words_left}, 32'd0);
        send_word(32'hB007_0000, 2);
        check_vec("t5_n0_hold", {31'd0, cpu_hold}, 32'd0);
        check_vec("t5_n0_wl", {16'd0, words_left}, 32'd0);
        load2(32'h0000_0300, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 2);
        check_vec("t5_nwr", wq_a.size() - base, 32'd2);
        check_vec("t5_a0", wq_a[base], 32'h0000_0300);
        check_vec("t5_a1", wq_a[base+1], 32'h0000_0304);
        check_vec("t5_d1", wq_d[base+1], 32'h0000_0007);
        check_vec("t5_done", done_cnt, 32'd3);

        // 6a. Timeout after 100 idle cycles in ADDR
        send_word(32'hB007_0001, 1);
        repeat (92) @(posedge clk);
        #1;
        check_vec("t6_no_tmo_yet", {31'd0, load_err}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check_vec("t6_tmo_err", {31'd0, load_err}, 32'd1);
        check_vec("t6_tmo_code", {30'd0, err_code}, 32'd0);
        check_vec("t6_tmo_hold", {31'd0, cpu_hold}, 32'd1);

        // 6b. Address wrap across the top of memory
        do_reset();
        base = wq_a.size();
        load2(32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0001, 32'h1234_5679, 1);
        check_vec("t6_nwr", wq_a.size() - base, 32'd2);
        check_vec("t6_a0", wq_a[base], 32'hFFFF_FFFC);
        check_vec("t6_a1", wq_a[base+1], 32'h0000_0000);
        check_vec("t6_done", done_cnt, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dbg_word_loader.md
Name: dbg_word_loader

Overview:
Debug-path program loader that sits directly downstream of the 32-bit UART word receiver. It consumes the receiver's assembled word and its word_end strobe, parses a framed load (header, base address, N data words, checksum), and issues word writes to instruction memory. It holds the CPU in reset for the whole load and reports success or a coded error.

Parameters:
MAGIC, 16'hB007, value required in header bits [31:16]
TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between words in ADDR/DATA/CSUM before a timeout error
TW, 27, width of the timeout counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
word_in  in  32  word from the UART word receiver (its instr output)
word_end  in  1  word-complete strobe from the receiver; may stay high for more than one cycle
mem_req  out  1  memory write request
mem_addr  out  32  byte address, word aligned
mem_wdata  out  32  write data
mem_ready  in  1  memory accepts the write in any cycle where mem_req=1 and mem_ready=1
cpu_hold  out  1  holds the CPU in reset while high
load_done  out  1  one-cycle pulse when a load completes successfully
load_err  out  1  sticky error flag
err_code  out  2  error cause: 0 timeout, 1 overrun, 2 misaligned address, 3 checksum
words_left  out  16  data words still to be written

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - Outputs: mem_req=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, err_code=0, words_left=0.
  - Internal state cleared: checksum, timeout counter and word_end_q.
  - Reset asserted mid-load aborts the load; no further mem_req is issued.
- Word event:
  - evt = word_end & ~word_end_q, where word_end_q is word_end registered.
  - word_in is sampled in the evt cycle.
  - A word_end that stays high for several cycles yields exactly one event.
- IDLE / ERROR, on evt:
  - Header is valid when word_in[31:16]==MAGIC and word_in[15:0]!=0.
  - Valid header: words_left<=word_in[15:0], checksum<=0, cpu_hold<=1, load_err<=0, err_code<=0, next state ADDR.
  - Any other word is ignored; the state is unchanged.
- ADDR, on evt:
  - If word_in[1:0]!=0: ERROR, code 2.
  - Otherwise: addr<=word_in, next state DATA.
- DATA, on evt:
  - mem_addr<=addr, mem_wdata<=word_in, mem_req<=1, checksum<=checksum+word_in (mod 2^32), next state WRITE.
  - mem_req rises the cycle after evt.
- WRITE:
  - mem_req stays high, with mem_addr and mem_wdata stable, until mem_ready=1.
  - In the accept cycle: mem_req<=0, addr<=addr+4 (wraps mod 2^32), words_left<=words_left-1.
  - Next state CSUM if words_left==1, else DATA.
  - Any evt while in WRITE: ERROR, code 1, mem_req<=0. If mem_ready is high in the same cycle, that write still counts as accepted.
- CSUM, on evt:
  - If word_in==checksum: next state DONE.
  - Otherwise: ERROR, code 3.
- DONE:
  - Lasts one cycle with load_done=1.
  - cpu_hold<=0, next state IDLE.
- ERROR:
  - load_err=1 and err_code hold their values.
  - cpu_hold stays 1.
  - mem_req=0.
  - Only a valid header leaves ERROR, restarting the load.
- Timeout:
  - Counter clears on state entry and on every evt.
  - Counter increments only in ADDR, DATA and CSUM.
  - When it reaches TIMEOUT_CYCLES-1: ERROR, code 0.
  - No timeout applies in WRITE.
- Latency: a data word's mem_req is issued 1 cycle after its evt.

Test Plan:
1. Normal load: header 0xB0070002, addr 0x00000100, data 0x11111111 and 0x22222222, csum 0x33333333, mem_ready=1.
   -> Writes (0x100, 0x11111111) and (0x104, 0x22222222).
   -> load_done pulses for 1 cycle; cpu_hold is high from the header until DONE; words_left steps 2→1→0.
2. Checksum mismatch: sequence as in 1 but csum 0x33333334.
   -> load_err=1, err_code=3, cpu_hold stays 1.
   -> A following valid header clears load_err and the load proceeds normally.
3. Misaligned address 0x00000102 after a valid header.
   -> err_code=2, no mem_req ever asserted.
4. Overrun: mem_ready held 0, second data word event arrives while the first write is pending.
   -> err_code=1, mem_req drops the next cycle.
5. word_end held high for 2 cycles per word, and a non-header word 0x00000041 sent in IDLE.
   -> One write per data word; 0x00000041 is ignored with no state change.
   -> Header 0xB0070000 (N=0) is also ignored.
6. TIMEOUT_CYCLES=100: header, then no word for 100 cycles -> err_code=0.
   Separate run: addr 0xFFFFFFFC, N=2 -> writes to 0xFFFFFFFC then 0x00000000.
